// File: rtl/fts_pkg.sv
// Shared types and constants for the fast-to-slow data hold transmitter.
package fts_pkg;

    typedef enum logic [1:0] {
        FTS_IDLE,
        FTS_ARMED,
        FTS_HOLD
    } fts_state_t;

    localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/slow_clk_edge_detect.sv
// Synchronises the slow clock into the fast domain and emits a one-cycle pulse per rising edge.
module slow_clk_edge_detect
    import fts_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic slow_clk_async_i,
    output logic slow_rise_o
);

    localparam int unsigned Msb = SYNC_STAGES - 1;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [SYNC_STAGES-1:0] fill_q, fill_d;
    logic                   s3_q, s3_d;
    logic                   seen_low_q, seen_low_d;

    always_comb begin
        sync_d     = {sync_q[Msb-1:0], slow_clk_async_i};
        fill_d     = {fill_q[Msb-1:0], 1'b1};
        s3_d       = sync_q[Msb];
        // The reset zeros in the chain are not real samples; only a genuine low arms detection.
        seen_low_d = seen_low_q | (fill_q[Msb] & ~sync_q[Msb]);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q     <= '0;
            fill_q     <= '0;
            s3_q       <= 1'b0;
            seen_low_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            fill_q     <= fill_d;
            s3_q       <= s3_d;
            seen_low_q <= seen_low_d;
        end
    end

    assign slow_rise_o = sync_q[Msb] & ~s3_q & seen_low_q;

endmodule

// File: rtl/fast_to_slow_data_hold.sv
// Fast-domain transmitter committing staged words to a held bus right after each slow rising edge.
// Optional FTS_SLOW_TIMEOUT_EN adds a sticky timeout when the slow clock stops.
module fast_to_slow_data_hold
    import fts_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 5,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  slow_clk_async,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_update,
    output logic                  busy,
    output logic                  slow_timeout
);

    fts_state_t            state_q, state_d;
    logic [DATA_WIDTH-1:0] stage_q, stage_d;
    logic                  stage_full_q, stage_full_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_update_q, out_update_d;
    logic                  slow_rise;
    logic                  accept;
    logic                  timeout_hit;

    slow_clk_edge_detect u_edge_detect (
        .clk_i            (clk),
        .rst_ni           (reset_n),
        .slow_clk_async_i (slow_clk_async),
        .slow_rise_o      (slow_rise)
    );

    assign in_ready = ~stage_full_q & reset_n;
    assign accept   = in_valid & in_ready;

`ifdef FTS_SLOW_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            timeout_q, timeout_d;

    always_comb begin
        cnt_d       = cnt_q + 1'b1;
        timeout_d   = timeout_q;
        timeout_hit = 1'b0;
        if (state_q == FTS_IDLE || slow_rise) begin
            cnt_d = '0;
        end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
            timeout_hit = 1'b1;
            timeout_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign slow_timeout = timeout_q;
`else
    assign timeout_hit  = 1'b0;
    assign slow_timeout = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        stage_d      = stage_q;
        stage_full_d = stage_full_q;
        out_data_d   = out_data_q;
        out_update_d = 1'b0;

        case (state_q)
            FTS_IDLE: begin
                // No same-edge bypass: a word always waits in stage for the next slow rise.
                if (accept) begin
                    stage_d      = in_data;
                    stage_full_d = 1'b1;
                    state_d      = FTS_ARMED;
                end
            end
            FTS_ARMED: begin
                if (slow_rise) begin
                    out_data_d   = stage_q;
                    out_update_d = 1'b1;
                    stage_full_d = 1'b0;
                    state_d      = FTS_HOLD;
                end
            end
            FTS_HOLD: begin
                if (accept) begin
                    stage_d      = in_data;
                    stage_full_d = 1'b1;
                end
                if (slow_rise) begin
                    if (stage_full_q) begin
                        out_data_d   = stage_q;
                        out_update_d = 1'b1;
                        stage_full_d = 1'b0;
                    end else if (accept) begin
                        state_d = FTS_ARMED;
                    end else begin
                        state_d = FTS_IDLE;
                    end
                end
            end
            default: state_d = FTS_IDLE;
        endcase

        // Abandon the pending word but leave the held bus untouched.
        if (timeout_hit) begin
            state_d      = FTS_IDLE;
            stage_d      = '0;
            stage_full_d = 1'b0;
            out_update_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= FTS_IDLE;
            stage_q      <= '0;
            stage_full_q <= 1'b0;
            out_data_q   <= '0;
            out_update_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            stage_q      <= stage_d;
            stage_full_q <= stage_full_d;
            out_data_q   <= out_data_d;
            out_update_q <= out_update_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_update = out_update_q;
    assign busy       = (state_q != FTS_IDLE);

endmodule
